// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   16x-oversampled UART receiver (8N1, LSB first) feeding a 16-entry
//   show-ahead FIFO.
//
// Ports
//   clk        in   system clock (single domain)
//   reset_n    in   asynchronous active-low reset
//   rxd        in   serial line, asynchronous, idles high
//   rd_data    out  byte at the FIFO head (8'h00 while empty)
//   rd_valid   out  FIFO non-empty
//   rd_ready   in   consumer pop request
//   fill       out  FIFO occupancy, 0..16
//   frame_err  out  one-cycle pulse on a bad stop bit
//   overrun    out  one-cycle pulse when a good byte is dropped (FIFO full)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge
// START | half a bit period into the start bit, confirm it is still low
// DATA  | sample eight data bits at bit centres, LSB first
// STOP  | sample the stop bit; good -> push, bad -> frame_err
// BREAK | line held low after a framing error; wait for it to go high

module uart_rx_fifo #(
    parameter int BAUD_DIV = 27,
    parameter int DEPTH    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [4:0] fill,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BREAK = 3'd4;

    logic             rxd_m;
    logic             rxd_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             start_entry;
    logic [2:0]       state;
    logic [3:0]       sample_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             push_pend;

    logic [7:0]       mem [DEPTH];
    logic [3:0]       wr_ptr;
    logic [3:0]       rd_ptr;
    logic             pop;
    logic             full;
    logic             push_acc;
    logic             push_drop;

    // ------------------------------------------------------------------
    // Input synchronizer; resets to the idle (high) line level.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // ------------------------------------------------------------------
    // 1/16-bit tick divider. Re-phased on start detection so that bit
    // centres line up with the falling edge of the start bit.
    // ------------------------------------------------------------------
    assign start_entry = (state == IDLE) && !rxd_s;
    assign tick        = (div_cnt == DIV_W'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (start_entry || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM. push_pend is a one-cycle request registered on the
    // stop-bit sample; the FIFO takes it on the following edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            push_pend  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push_pend <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state      <= START;
                        sample_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt == 4'd7) begin
                            sample_cnt <= '0;
                            bit_cnt    <= '0;
                            state      <= rxd_s ? IDLE : DATA;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sample_cnt == 4'd15) begin
                            sample_cnt <= '0;
                            shift_reg  <= {rxd_s, shift_reg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sample_cnt == 4'd15) begin
                            sample_cnt <= '0;
                            if (rxd_s) begin
                                push_pend <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO. A pop in the same cycle frees the slot for a push
    // when full, so the byte is accepted rather than dropped.
    // ------------------------------------------------------------------
    assign rd_valid  = (fill != 5'd0);
    assign rd_data   = rd_valid ? mem[rd_ptr] : 8'h00;
    assign pop       = rd_valid && rd_ready;
    assign full      = (fill == 5'(DEPTH));
    assign push_acc  = push_pend && (!full || pop);
    assign push_drop = push_pend && full && !pop;

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_drop;
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill <= fill + 5'(push_acc) - 5'(pop);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int BAUD_DIV = 4;
    localparam int BIT_CLK  = 64;

    logic       clk;
    logic       reset_n;
    logic       rxd;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] fill;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int exp_fe   = 0;
    int exp_ov   = 0;

    // reference model: bytes the receiver should currently hold, in order
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.BAUD_DIV(BAUD_DIV), .DEPTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rxd       (rxd),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .fill      (fill),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops the model on every handshake and counts pulses
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got %02h expected no data", rd_data);
                end else begin
                    check("pop_data", rd_data, exp_q.pop_front());
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (frame_err || overrun)
                check("pulse_exclusive", frame_err && overrun, 0);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a clock edge. Model decision is made up front.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int extra_low, input bit pop_at_push);
        if (stop) begin
            if (exp_q.size() >= 16 && !pop_at_push) exp_ov++;
            else exp_q.push_back(b);
        end else begin
            exp_fe++;
        end
        rxd = 1'b0;
        wait_edges(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_edges(BIT_CLK);
        end
        rxd = stop;
        if (pop_at_push) begin
            // the byte is written on the 612th edge after the start edge
            wait_edges(35);
            rd_ready = 1'b1;
            wait_edges(1);
            rd_ready = 1'b0;
            wait_edges(28);
        end else begin
            wait_edges(BIT_CLK);
        end
        if (!stop) wait_edges(extra_low);
        rxd = 1'b1;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        rd_ready = 1'b1;
        while (fill != 0 && guard < 64) begin
            wait_edges(1);
            guard++;
        end
        rd_ready = 1'b0;
        check(name, fill, 0);
        check({name, "_model"}, exp_q.size(), 0);
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        logic st;

        reset_n  = 1'b0;
        rxd      = 1'b1;
        rd_ready = 1'b0;
        #23;
        check("rst_fill", fill, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 8'h00);
        check("rst_pulses", {frame_err, overrun}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        wait_edges(10);

        // single good byte, with latency from the start edge
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 0, 1'b0);
            begin
                while (!rd_valid && lat < 700) begin
                    wait_edges(1);
                    lat++;
                end
            end
        join
        check("a5_latency_ok", (lat >= 611 && lat <= 613), 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_fill", fill, 1);
        wait_edges(16);
        drain("a5_drain");

        // start-bit glitch
        rxd = 1'b0;
        wait_edges(20);
        rxd = 1'b1;
        wait_edges(100);
        check("glitch_fill", fill, 0);
        check("glitch_valid", rd_valid, 0);
        check("glitch_fe", fe_cnt, exp_fe);

        // bad stop bit, long break, then a good byte
        send_frame(8'h3C, 1'b0, 200, 1'b0);
        wait_edges(16);
        check("fe_count", fe_cnt, 1);
        check("fe_fill", fill, 0);
        send_frame(8'h11, 1'b1, 0, 1'b0);
        wait_edges(16);
        check("after_break_data", rd_data, 8'h11);
        check("after_break_fill", fill, 1);
        drain("break_drain");

        // fill to 16, 17th byte overruns
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 0, 1'b0);
            wait_edges(16);
        end
        check("full_fill", fill, 16);
        check("ov_count", ov_cnt, 1);
        check("full_head", rd_data, 8'h00);
        drain("full_drain");

        // push and pop on the same edge while full
        for (int i = 0; i < 16; i++) begin
            send_frame(8'(8'h20 + i), 1'b1, 0, 1'b0);
            wait_edges(16);
        end
        check("full2_fill", fill, 16);
        send_frame(8'h55, 1'b1, 0, 1'b1);
        wait_edges(16);
        check("simul_fill", fill, 16);
        check("simul_ov", ov_cnt, exp_ov);
        drain("simul_drain");

        // reset in the middle of DATA
        rxd = 1'b0;
        wait_edges(BIT_CLK);
        b = 8'h77;
        for (int i = 0; i < 3; i++) begin
            rxd = b[i];
            wait_edges(BIT_CLK);
        end
        reset_n = 1'b0;
        rxd     = 1'b1;
        #1;
        check("midrst_fill", fill, 0);
        check("midrst_valid", rd_valid, 0);
        check("midrst_pulses", {frame_err, overrun}, 0);
        exp_q.delete();
        wait_edges(5);
        reset_n = 1'b1;
        wait_edges(20);
        send_frame(8'h9E, 1'b1, 0, 1'b0);
        wait_edges(16);
        check("midrst_rx_data", rd_data, 8'h9E);
        check("midrst_rx_fill", fill, 1);
        drain("midrst_drain");

        // randomized traffic
        for (int k = 0; k < 10; k++) begin
            b  = 8'($urandom_range(0, 255));
            st = ($urandom_range(0, 4) != 0);
            rd_ready = 1'($urandom_range(0, 1));
            send_frame(b, st, st ? 0 : $urandom_range(10, 100), 1'b0);
            wait_edges(16 + $urandom_range(0, 20));
            check("rand_fill", fill, exp_q.size());
        end
        drain("rand_drain");

        check("total_fe", fe_cnt, exp_fe);
        check("total_ov", ov_cnt, exp_ov);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 27, meaning clk cycles per 1/16 bit period (50 MHz / 115200 baud / 16).
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; fixed at 16 in this revision.
REQ-003 clk  in  1  system clock; one clock domain only.
REQ-004 reset_n  in  1  reset; asynchronous, active-low.
REQ-005 rxd  in  1  serial line from UART_RXD; asynchronous to clk; idles high.
REQ-006 rd_data  out  8  byte at the FIFO head.
REQ-007 rd_valid  out  1  FIFO non-empty; rd_data is valid.
REQ-008 rd_ready  in  1  consumer pop request.
REQ-009 fill  out  5  FIFO occupancy, 0..16.
REQ-010 frame_err  out  1  one-cycle pulse on a bad stop bit.
REQ-011 overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (rxd_s) before use; both flops reset to 1.
REQ-013 The tick divider SHALL count 0..BAUD_DIV-1 and assert tick for one cycle at BAUD_DIV-1; the divider clears whenever the FSM enters START.
REQ-014 The FSM SHALL use states IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: rxd_s==0 SHALL move the FSM to START, with the tick counter and sample counter cleared.
REQ-016 START: on the 8th tick, rxd_s==0 SHALL move the FSM to DATA; rxd_s==1 SHALL move it to IDLE (glitch rejected, no outputs).
REQ-017 DATA: every 16th tick SHALL sample rxd_s into a shift register, LSB first; after the 8th bit the FSM SHALL move to STOP.
REQ-018 STOP: on the 16th tick, rxd_s==1 SHALL push the byte and go to IDLE; rxd_s==0 SHALL pulse frame_err, discard the byte, and go to BREAK.
REQ-019 BREAK: the FSM SHALL stay in BREAK until rxd_s==1, then go to IDLE.
REQ-020 A push SHALL write the FIFO on the cycle after the stop-bit sample, so rd_valid rises that same cycle when the FIFO was empty.
REQ-021 The FIFO SHALL be show-ahead: rd_valid = (fill!=0) and rd_data = mem[rd_ptr] combinationally from registered state.
REQ-022 A pop SHALL occur when rd_valid && rd_ready; it advances rd_ptr and decrements fill on that clock edge.
REQ-023 Pointers SHALL be 4 bits and wrap 15->0 naturally.
REQ-024 Push while fill==16 with no pop in the same cycle SHALL drop the byte, pulse overrun, and leave the FIFO unchanged.
REQ-025 Push and pop in the same cycle while full SHALL accept both: no overrun, fill stays 16.
REQ-026 Push and pop in the same cycle while empty cannot occur, because rd_valid=0; the push is taken and fill becomes 1.
REQ-027 rd_ready while rd_valid==0 SHALL be ignored.
REQ-028 frame_err and overrun SHALL never assert in the same cycle.

Reset
REQ-029 reset_n low SHALL immediately set: FSM=IDLE, all counters 0, rd_ptr=wr_ptr=0, fill=0, rd_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-030 rd_data SHALL read 8'h00 while fill==0 after reset; FIFO memory need not be cleared.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no push and no pulse; after release the next full frame SHALL be received correctly.

Verification (BAUD_DIV=4, bit period 64 clk)
REQ-032 Send 0xA5 with a good stop bit -> rd_valid=1, rd_data=0xA5, fill=1, within 2 cycles after the stop-bit midpoint.
REQ-033 Drive rxd low for 20 clk, then high -> no push, FSM returns to IDLE, fill=0.
REQ-034 Send 0x3C with stop bit 0, hold rxd low 200 clk, then send 0x11 -> exactly one frame_err pulse, 0x3C never appears, then rd_data=0x11 and fill=1.
REQ-035 Send 0x00..0x10 (17 bytes) with rd_ready=0 -> fill=16, one overrun pulse on the 17th byte; then popping 16 times yields 0x00..0x0F in order, fill=0.
REQ-036 With fill=16, assert rd_ready on the push cycle of a new byte 0x55 -> no overrun, fill=16, 0x55 read out last.
REQ-037 Pulse reset_n low during DATA of 0x77, then send 0x9E -> only 0x9E is received, fill=1.
